requantize_pc: RTL and testbench

REQUANTIZE_PC -- requirements
Module: requantize_pc

---
 rtl/requantize_pc.sv | 208 ++++++++++++++++++++
 tb/tb_requantize_pc.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/requantize_pc.sv
// requantize_pc: per-channel requantization of accumulator beats to signed
// OUT_W activations.
//
// Each beat carries LANES accumulators for one channel group; the group index
// advances per accepted beat and wraps after GROUPS-1. Lane k of group g uses
// table entry g*LANES+k = {scale, shift, zp}.
//   stage 1: p = acc * scale           (signed, IN_W+SCALE_W+1 bits, exact)
//   stage 2: q = p >>> shift           (floor; round half up with REQUANT_ROUND_EN)
//   stage 3: out = clamp(q + zp, lo, 2^(OUT_W-1)-1), lo = act_mode ? zp : -2^(OUT_W-1)
// The whole pipeline stalls together: advance = !out_valid || out_ready.
//
// Optional feature macro: REQUANT_ROUND_EN (rounding in stage 2).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_valid/in_ready   LANES x IN_W signed accumulator beat, handshake
//   act_mode              0 = linear, 1 = ReLU (sampled at acceptance)
//   cfg_we/cfg_addr/cfg_scale/cfg_shift/cfg_zp   parameter-table write port
//   out_data/out_valid/out_ready   LANES x OUT_W signed result beat, handshake
//   out_last              beat belongs to group GROUPS-1
module requantize_pc #(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int SCALE_W = 16,
    parameter int LANES   = 16,
    parameter int NUM_CH  = 64,
    localparam int AW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LANES*IN_W-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     act_mode,
    input  logic                     cfg_we,
    input  logic [AW-1:0]            cfg_addr,
    input  logic [SCALE_W-1:0]       cfg_scale,
    input  logic [5:0]               cfg_shift,
    input  logic signed [OUT_W-1:0]  cfg_zp,
    output logic [LANES*OUT_W-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    localparam int GROUPS = NUM_CH / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int P_W    = IN_W + SCALE_W + 1;
    localparam int S_W    = P_W + 1;
    localparam logic signed [S_W-1:0] HI     = S_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [S_W-1:0] LO_LIN = -HI - S_W'(1);

    // ---------------- parameter table (not reset) ----------------
    logic [SCALE_W-1:0]      scale_tab [NUM_CH];
    logic [5:0]              shift_tab [NUM_CH];
    logic signed [OUT_W-1:0] zp_tab    [NUM_CH];

    always_ff @(posedge clk) begin
        if (cfg_we) begin
            scale_tab[cfg_addr] <= cfg_scale;
            shift_tab[cfg_addr] <= cfg_shift;
            zp_tab[cfg_addr]    <= cfg_zp;
        end
    end

    // ---------------- handshake and group counter ----------------
    logic advance;
    logic accept;
    logic [GW-1:0] grp;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp <= '0;
        end else if (accept) begin
            grp <= (grp == GW'(GROUPS - 1)) ? '0 : grp + GW'(1);
        end
    end

    // ---------------- stage 1: table read and multiply ----------------
    logic signed [P_W-1:0]   s1_p_d  [LANES];
    logic [5:0]              s1_sh_d [LANES];
    logic signed [OUT_W-1:0] s1_zp_d [LANES];
    logic [AW-1:0]           base;
    logic [AW-1:0]           ch;
    logic signed [P_W-1:0]   mul_a;
    logic signed [P_W-1:0]   mul_b;

    always_comb begin
        base  = AW'(grp) * AW'(LANES);
        ch    = '0;
        mul_a = '0;
        mul_b = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            ch          = base + AW'(k);
            mul_a       = P_W'($signed(in_data[k*IN_W +: IN_W]));
            mul_b       = $signed(P_W'({1'b0, scale_tab[ch]}));
            s1_p_d[k]   = mul_a * mul_b;
            s1_sh_d[k]  = shift_tab[ch];
            s1_zp_d[k]  = zp_tab[ch];
        end
    end

    logic signed [P_W-1:0]   s1_p  [LANES];
    logic [5:0]              s1_sh [LANES];
    logic signed [OUT_W-1:0] s1_zp [LANES];
    logic                    s1_act;
    logic                    s1_last;
    logic                    s1_v;

    // ---------------- stage 2: shift ----------------
    logic signed [P_W-1:0] s2_q_d [LANES];
`ifdef REQUANT_ROUND_EN
    logic signed [S_W-1:0] rnd;
`endif

    always_comb begin
`ifdef REQUANT_ROUND_EN
        rnd = '0;
`endif
        for (int unsigned k = 0; k < LANES; k++) begin
`ifdef REQUANT_ROUND_EN
            // one extra bit keeps p + 2^(shift-1) from wrapping; shifts past
            // the product width round to exactly zero
            if (s1_sh[k] == 6'd0) begin
                s2_q_d[k] = s1_p[k];
            end else if (int'(s1_sh[k]) >= P_W) begin
                s2_q_d[k] = '0;
            end else begin
                rnd       = S_W'(s1_p[k]) + (S_W'(1) << (s1_sh[k] - 6'd1));
                s2_q_d[k] = P_W'(rnd >>> s1_sh[k]);
            end
`else
            if (int'(s1_sh[k]) >= P_W - 1) begin
                s2_q_d[k] = {P_W{s1_p[k][P_W-1]}};
            end else begin
                s2_q_d[k] = s1_p[k] >>> s1_sh[k];
            end
`endif
        end
    end

    logic signed [P_W-1:0]   s2_q  [LANES];
    logic signed [OUT_W-1:0] s2_zp [LANES];
    logic                    s2_act;
    logic                    s2_last;
    logic                    s2_v;

    // ---------------- stage 3: zero point and clamp ----------------
    logic [LANES*OUT_W-1:0] out_d;
    logic signed [S_W-1:0]  sum;
    logic signed [S_W-1:0]  lo;

    always_comb begin
        out_d = '0;
        sum   = '0;
        lo    = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            sum = S_W'(s2_q[k]) + S_W'(s2_zp[k]);
            lo  = s2_act ? S_W'(s2_zp[k]) : LO_LIN;
            if (sum > HI) begin
                sum = HI;
            end else if (sum < lo) begin
                sum = lo;
            end
            out_d[k*OUT_W +: OUT_W] = sum[OUT_W-1:0];
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            s1_v      <= in_valid;
            s2_v      <= s1_v;
            out_valid <= s2_v;
            if (s2_v) begin
                out_data <= out_d;
                out_last <= s2_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_p    <= s1_p_d;
            s1_sh   <= s1_sh_d;
            s1_zp   <= s1_zp_d;
            s1_act  <= act_mode;
            s1_last <= (grp == GW'(GROUPS - 1));
        end
        if (advance && s1_v) begin
            s2_q    <= s2_q_d;
            s2_zp   <= s1_zp;
            s2_act  <= s1_act;
            s2_last <= s1_last;
        end
    end

endmodule

// File: tb/tb_requantize_pc.sv
// tb_requantize_pc: directed bench for requantize_pc at default parameters
// (LANES=16, NUM_CH=64, GROUPS=4). A reference table mirror and a small
// arithmetic model predict every beat; directed values are checked by hand.
module tb_requantize_pc;

    localparam int LANES = 16;
    localparam int IN_W  = 32;
    localparam int OUT_W = 8;
    localparam int GROUPS = 4;
`ifdef REQUANT_ROUND_EN
    localparam logic [7:0] L0_EXP = 8'd8;
`else
    localparam logic [7:0] L0_EXP = 8'd7;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [LANES*IN_W-1:0]      in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic                       act_mode;
    logic                       cfg_we;
    logic [5:0]                 cfg_addr;
    logic [15:0]                cfg_scale;
    logic [5:0]                 cfg_shift;
    logic signed [7:0]          cfg_zp;
    logic [LANES*OUT_W-1:0]     out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;

    requantize_pc #(.IN_W(32), .OUT_W(8), .SCALE_W(16), .LANES(16), .NUM_CH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .act_mode(act_mode),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_scale(cfg_scale),
        .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0]       m_scale [64];
    int                m_shift [64];
    logic signed [7:0] m_zp    [64];

    logic [127:0] exp_q [$];
    bit           exp_lq [$];
    logic [127:0] cap_d [512];
    bit           cap_l [512];
    int           cap_c [512];
    int           n_out = 0;
    int           n_acc = 0;
    int           cyc = 0;
    int           g = 0;
    int           acc_cyc0 = 0;
    bit           last_acc = 0;
    bit           prev_stall = 0;
    logic [127:0] prev_d;
    logic         prev_l;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input longint acc, input int c, input bit act);
        longint p, q, s, lo;
        int sh;
        p  = acc * longint'(m_scale[c]);
        sh = m_shift[c];
`ifdef REQUANT_ROUND_EN
        if (sh == 0) q = p;
        else q = (p + (longint'(1) <<< (sh - 1))) >>> sh;
`else
        q = p >>> sh;
`endif
        s  = q + longint'(m_zp[c]);
        lo = act ? longint'(m_zp[c]) : -128;
        if (s > 127) s = 127;
        if (s < lo) s = lo;
        return s[7:0];
    endfunction

    // One clock cycle: sample at negedge, score, then advance to posedge+1.
    task automatic step();
        logic [127:0] ev;
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, prev_d);
            chk("stall_last", out_last, prev_l);
        end
        chk("in_ready_rule", in_ready, !out_valid || out_ready);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_out", 1'b1, 1'b0);
            end else begin
                chk("out_data", out_data, exp_q[0]);
                chk("out_last", out_last, exp_lq[0]);
                void'(exp_q.pop_front());
                void'(exp_lq.pop_front());
                cap_d[n_out] = out_data;
                cap_l[n_out] = out_last;
                cap_c[n_out] = cyc;
                n_out++;
            end
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            ev = '0;
            for (int k = 0; k < LANES; k++)
                ev[k*8 +: 8] = model(longint'($signed(in_data[k*32 +: 32])), g*LANES + k, act_mode);
            exp_q.push_back(ev);
            exp_lq.push_back(g == GROUPS - 1);
            if (n_acc == 0) acc_cyc0 = cyc;
            g = (g + 1) % GROUPS;
            n_acc++;
        end
        if (cfg_we) begin
            m_scale[cfg_addr] = cfg_scale;
            m_shift[cfg_addr] = int'(cfg_shift);
            m_zp[cfg_addr]    = cfg_zp;
        end
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data;
        prev_l     = out_last;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int budget;
        budget = 60;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        chk("drain_timeout", exp_q.size(), 0);
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        int base, v, budget, tgt;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; act_mode = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_scale = '0; cfg_shift = '0; cfg_zp = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_data", out_data, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // table: entry 0 {3,2,0}, entries 1/2 {1,0,-5}, others patterned
        for (int c = 0; c < 64; c++) begin
            cfg_we    = 1'b1;
            cfg_addr  = 6'(c);
            cfg_scale = 16'(c + 1);
            cfg_shift = 6'(c % 5);
            cfg_zp    = 8'((c % 7) - 3);
            if (c == 0) begin cfg_scale = 16'd3; cfg_shift = 6'd2; cfg_zp = 8'sd0; end
            if (c == 1 || c == 2) begin cfg_scale = 16'd1; cfg_shift = 6'd0; cfg_zp = -8'sd5; end
            step();
        end
        cfg_we = 1'b0;

        // 8 back-to-back beats, out_ready held high
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            act_mode = (i >= 4);
            for (int k = 0; k < LANES; k++) in_data[k*32 +: 32] = 32'(i*1000 + k*77 - 3000);
            if (i == 0) begin
                in_data[0*32 +: 32] = 32'd10;
                in_data[1*32 +: 32] = -32'sd200;
                in_data[2*32 +: 32] = 32'd1000;
            end
            if (i == 4) begin
                in_data[0*32 +: 32] = 32'd10;
                in_data[1*32 +: 32] = -32'sd200;
            end
            step();
        end
        drain();
        chk("burst_count", n_out - base, 8);
        chk("burst_latency", cap_c[base] - acc_cyc0, 3);
        chk("burst_back_to_back", cap_c[base+7] - cap_c[base], 7);
        chk("lane0_acc10", cap_d[base][7:0], L0_EXP);
        chk("clamp_lo_linear", cap_d[base][15:8], 8'h80);
        chk("clamp_hi", cap_d[base][23:16], 8'h7f);
        chk("clamp_lo_relu", cap_d[base+4][15:8], 8'hfb);
        chk("last_out1", cap_l[base], 1'b0);
        chk("last_out4", cap_l[base+3], 1'b1);
        chk("last_out8", cap_l[base+7], 1'b1);

        // random backpressure, 100 beats
        tgt = n_acc + 100;
        budget = 2000;
        in_valid = 1'b0;
        while (n_acc < tgt && budget > 0) begin
            out_ready = ($urandom_range(0, 1) == 1);
            if (last_acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                act_mode = ($urandom_range(0, 1) == 1);
                for (int k = 0; k < LANES; k++) begin
                    v = $urandom;
                    v = v >>> $urandom_range(0, 24);
                    in_data[k*32 +: 32] = v;
                end
            end
            step();
            budget--;
        end
        chk("random_timeout", n_acc >= tgt, 1'b1);
        drain();

        // reset with two beats in flight
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            for (int k = 0; k < LANES; k++) in_data[k*32 +: 32] = 32'(k*5 + i);
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, '0);
        exp_q.delete();
        exp_lq.delete();
        g = 0;
        prev_stall = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = n_out;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            act_mode = 1'b0;
            for (int k = 0; k < LANES; k++) in_data[k*32 +: 32] = 32'(k*13 - 100 + i*7);
            step();
        end
        drain();
        chk("post_rst_count", n_out - base, 4);
        chk("post_rst_last1", cap_l[base], 1'b0);
        chk("post_rst_last3", cap_l[base+2], 1'b0);
        chk("post_rst_last4", cap_l[base+3], 1'b1);

        // cfg write to entry 0 on the same edge as a group-0 acceptance
        base = n_out;
        in_valid = 1'b1;
        act_mode = 1'b0;
        in_data  = '0;
        in_data[31:0] = 32'd10;
        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_scale = 16'd5; cfg_shift = 6'd0; cfg_zp = 8'sd0;
        step();
        cfg_we = 1'b0;
        for (int i = 0; i < 4; i++) step();
        drain();
        chk("cfg_same_edge_count", n_out - base, 5);
        chk("cfg_same_edge_old", cap_d[base][7:0], L0_EXP);
        chk("cfg_next_group0_new", cap_d[base+4][7:0], 8'd50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
